// File: rtl/morse_encoder.sv
// morse_encoder: serialises one ASCII character per handshake into an on/off Morse key waveform.
module morse_encoder #(
    parameter int TICK_DIV = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_valid,
    input  logic [7:0] i_data,
    output logic       o_ready,
    output logic       o_key,
    output logic       o_busy,
    output logic       o_err,
    output logic       o_eom
);
    localparam int DW = $clog2(TICK_DIV) + 1;
    typedef enum logic [1:0] {IDLE, SEND, HALT} state_t;
    state_t state, state_n;
    logic [19:0] sr, sr_n, code;
    logic [4:0] cnt, cnt_n, len;
    logic [DW-1:0] div, div_n;
    logic plus, plus_n, hit, wrap;
    always_comb begin
        code = '0;
        len = '0;
        hit = 1'b1;
        case (i_data)
            8'd72: begin code = 20'b1010101000; len = 5'd10; end
            8'd69: begin code = 20'b1000; len = 5'd4; end
            8'd82: begin code = 20'b1011101000; len = 5'd10; end
            8'd65: begin code = 20'b10111000; len = 5'd8; end
            8'd83: begin code = 20'b10101000; len = 5'd8; end
            8'd67: begin code = 20'b11101011101000; len = 5'd14; end
            8'd78: begin code = 20'b11101000; len = 5'd8; end
            8'd75: begin code = 20'b111010111000; len = 5'd12; end
            8'd79: begin code = 20'b11101110111000; len = 5'd14; end
            8'd95: begin code = 20'b1110101010111000; len = 5'd16; end
            8'd84: begin code = 20'b111000; len = 5'd6; end
            8'd77: begin code = 20'b1110111000; len = 5'd10; end
            8'd68: begin code = 20'b1110101000; len = 5'd10; end
            8'd57: begin code = 20'b11101110111011101000; len = 5'd20; end
            8'd49: begin code = 20'b10111011101110111000; len = 5'd20; end
            8'd43: begin code = 20'b1011101011101000; len = 5'd16; end
            default: hit = 1'b0;
        endcase
    end
    assign wrap = div == DW'(TICK_DIV - 1);
    // Patterns are stored right-aligned and shifted so the first element sits at bit 19.
    always_comb begin
        state_n = state;
        sr_n = sr;
        cnt_n = cnt;
        div_n = div;
        plus_n = plus;
        case (state)
            IDLE: if (i_valid && hit) begin
                state_n = SEND;
                sr_n = code << (5'd20 - len);
                cnt_n = len;
                div_n = '0;
                plus_n = i_data == 8'd43;
            end
            SEND: if (cnt == 5'd0) begin
                state_n = plus ? HALT : IDLE;
            end else begin
                div_n = wrap ? '0 : div + 1'b1;
                sr_n = wrap ? sr << 1 : sr;
                cnt_n = wrap ? cnt - 5'd1 : cnt;
            end
            default: state_n = HALT;
        endcase
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
            sr <= '0;
            cnt <= '0;
            div <= '0;
            plus <= 1'b0;
            o_ready <= 1'b1;
            o_key <= 1'b0;
            o_busy <= 1'b0;
            o_err <= 1'b0;
            o_eom <= 1'b0;
        end else begin
            state <= state_n;
            sr <= sr_n;
            cnt <= cnt_n;
            div <= div_n;
            plus <= plus_n;
            o_ready <= state_n == IDLE;
            o_key <= state == SEND && cnt != 5'd0 && sr[19];
            o_busy <= state_n == SEND;
            o_err <= state == IDLE && i_valid && !hit;
            o_eom <= state_n == HALT;
        end
    end
endmodule

// File: tb/tb_morse_encoder.sv
// tb_morse_encoder: directed checks of the Morse encoder at TICK_DIV=4 and TICK_DIV=1.
module tb_morse_encoder;
    logic clk = 1'b0, rst = 1'b1, valid = 1'b0, valid1 = 1'b0;
    logic [7:0] data = 8'd0, data1 = 8'd0;
    logic ready, key, busy, err, eom;
    logic ready1, key1, busy1, err1, eom1;
    int checks = 0, errors = 0;
    always #5 clk = ~clk;
    morse_encoder #(.TICK_DIV(4)) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_data(data),
        .o_ready(ready), .o_key(key), .o_busy(busy), .o_err(err), .o_eom(eom)
    );
    morse_encoder #(.TICK_DIV(1)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_valid(valid1), .i_data(data1),
        .o_ready(ready1), .o_key(key1), .o_busy(busy1), .o_err(err1), .o_eom(eom1)
    );
    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({ready, key, busy, err, eom} !== 5'b10000) begin
            errors++;
            $display("FAIL reset rdy/key/busy/err/eom=%b exp=10000", {ready, key, busy, err, eom});
        end
        checks++;
        if ({ready1, key1, busy1, err1, eom1} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_t1 rdy/key/busy/err/eom=%b exp=10000", {ready1, key1, busy1, err1, eom1});
        end
        @(negedge clk) rst = 1'b0;
    endtask
    task automatic test_e;
        logic [3:0] pat = 4'b1000;
        @(negedge clk);
        valid = 1'b1;
        data = 8'd69;
        @(posedge clk);
        #1 valid = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (key !== pat[3 - (c - 1) / 4] || ready !== 1'b0 || busy !== 1'b1 || err !== 1'b0) begin
                errors++;
                $display("FAIL e_cycle%0d key=%b rdy=%b busy=%b err=%b exp key=%b rdy=0 busy=1 err=0",
                         c, key, ready, busy, err, pat[3 - (c - 1) / 4]);
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if ({ready, busy, key, err} !== 4'b1000) begin
            errors++;
            $display("FAIL e_done rdy/busy/key/err=%b exp=1000", {ready, busy, key, err});
        end
    endtask
    task automatic test_a;
        logic [7:0] pat = 8'b10111000;
        @(negedge clk);
        valid = 1'b1;
        data = 8'd65;
        @(posedge clk);
        #1 valid = 1'b0;
        for (int c = 1; c <= 32; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (key !== pat[7 - (c - 1) / 4] || ready !== 1'b0) begin
                errors++;
                $display("FAIL a_cycle%0d key=%b rdy=%b exp key=%b rdy=0", c, key, ready, pat[7 - (c - 1) / 4]);
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if ({ready, busy, key} !== 3'b100) begin
            errors++;
            $display("FAIL a_done rdy/busy/key=%b exp=100", {ready, busy, key});
        end
    endtask
    task automatic test_unknown;
        @(negedge clk);
        valid = 1'b1;
        data = 8'd90;
        @(posedge clk);
        #1 valid = 1'b0;
        checks++;
        if ({err, ready, key, busy} !== 4'b1100) begin
            errors++;
            $display("FAIL unknown_pulse err/rdy/key/busy=%b exp=1100", {err, ready, key, busy});
        end
        @(posedge clk);
        #1;
        checks++;
        if ({err, ready, key, busy} !== 4'b0100) begin
            errors++;
            $display("FAIL unknown_after err/rdy/key/busy=%b exp=0100", {err, ready, key, busy});
        end
    endtask
    task automatic test_stream;
        logic [19:0] pats [3];
        int lens [3];
        logic [7:0] chs [4];
        pats[0] = 20'b1010101000_0000000000;
        pats[1] = 20'b1000_0000000000000000;
        pats[2] = 20'b1011101011101000_0000;
        lens[0] = 10;
        lens[1] = 4;
        lens[2] = 16;
        chs[0] = 8'd72;
        chs[1] = 8'd69;
        chs[2] = 8'd43;
        chs[3] = 8'd84;
        @(negedge clk);
        valid = 1'b1;
        data = chs[0];
        @(posedge clk);
        #1;
        for (int j = 0; j < 3; j++) begin
            checks++;
            if (ready !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL stream_accept%0d rdy=%b busy=%b exp rdy=0 busy=1", j, ready, busy);
            end
            data = chs[j + 1];
            for (int c = 1; c <= lens[j] * 4; c++) begin
                @(posedge clk);
                #1;
                checks++;
                if (key !== pats[j][19 - (c - 1) / 4] || ready !== 1'b0) begin
                    errors++;
                    $display("FAIL stream%0d_cycle%0d key=%b rdy=%b exp key=%b rdy=0",
                             j, c, key, ready, pats[j][19 - (c - 1) / 4]);
                end
            end
            @(posedge clk);
            #1;
            checks++;
            if (j < 2) begin
                if ({ready, busy, key} !== 3'b100) begin
                    errors++;
                    $display("FAIL stream%0d_idle rdy/busy/key=%b exp=100", j, {ready, busy, key});
                end
                @(posedge clk);
                #1;
            end else if ({eom, ready, busy, key} !== 4'b1000) begin
                errors++;
                $display("FAIL stream_halt eom/rdy/busy/key=%b exp=1000", {eom, ready, busy, key});
            end
        end
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({eom, ready, busy, key} !== 4'b1000) begin
                errors++;
                $display("FAIL halt_hold%0d eom/rdy/busy/key=%b exp=1000", c, {eom, ready, busy, key});
            end
        end
        @(negedge clk) valid = 1'b0;
    endtask
    task automatic test_reset_mid;
        logic [19:0] p9 = 20'b11101110111011101000;
        logic [5:0] pt = 6'b111000;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({ready, key, busy, err, eom} !== 5'b10000) begin
            errors++;
            $display("FAIL halt_reset rdy/key/busy/err/eom=%b exp=10000", {ready, key, busy, err, eom});
        end
        @(negedge clk);
        valid = 1'b1;
        data = 8'd84;
        @(posedge clk);
        #1;
        checks++;
        if ({ready, busy, key} !== 3'b100) begin
            errors++;
            $display("FAIL rst_priority rdy/busy/key=%b exp=100", {ready, busy, key});
        end
        @(negedge clk);
        rst = 1'b0;
        data = 8'd57;
        @(posedge clk);
        #1 valid = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (key !== p9[19 - (c - 1) / 4] || busy !== 1'b1) begin
                errors++;
                $display("FAIL nine_cycle%0d key=%b busy=%b exp key=%b busy=1", c, key, busy, p9[19 - (c - 1) / 4]);
            end
        end
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({ready, key, busy, err, eom} !== 5'b10000) begin
            errors++;
            $display("FAIL mid_reset rdy/key/busy/err/eom=%b exp=10000", {ready, key, busy, err, eom});
        end
        @(negedge clk);
        rst = 1'b0;
        valid = 1'b1;
        data = 8'd84;
        @(posedge clk);
        #1 valid = 1'b0;
        for (int c = 1; c <= 24; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (key !== pt[5 - (c - 1) / 4] || ready !== 1'b0) begin
                errors++;
                $display("FAIL t_cycle%0d key=%b rdy=%b exp key=%b rdy=0", c, key, ready, pt[5 - (c - 1) / 4]);
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if ({ready, busy, key} !== 3'b100) begin
            errors++;
            $display("FAIL t_done rdy/busy/key=%b exp=100", {ready, busy, key});
        end
    endtask
    task automatic test_tick1;
        logic [5:0] pt = 6'b111000;
        @(negedge clk);
        valid1 = 1'b1;
        data1 = 8'd84;
        @(posedge clk);
        #1 valid1 = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (key1 !== pt[6 - c] || ready1 !== 1'b0 || busy1 !== 1'b1) begin
                errors++;
                $display("FAIL t1_cycle%0d key=%b rdy=%b busy=%b exp key=%b rdy=0 busy=1",
                         c, key1, ready1, busy1, pt[6 - c]);
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if ({ready1, busy1, key1} !== 3'b100) begin
            errors++;
            $display("FAIL t1_done rdy/busy/key=%b exp=100", {ready1, busy1, key1});
        end
    endtask
    initial begin
        test_reset;
        test_e;
        test_a;
        test_unknown;
        test_stream;
        test_reset_mid;
        test_tick1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
